// File: rtl/pdm_multichannel_frontend.sv
// pdm_multichannel_frontend: PDM mic clock generator, 1/2-channel capture, per-channel CIC decimation, tagged PCM FIFO.
// Ports: clk/rst_n (async active-low) system clock and reset; enable starts capture;
//        M_CLK/M_LRSEL/M_DATA microphone pins; pcm_data/pcm_channel/pcm_valid/pcm_ready
//        first-word-fall-through output; overflow (sticky drop flag) cleared by overflow_clr.
// Option: define PDM_DC_BLOCK_EN to insert a saturating per-channel DC blocker after the CIC.
module pdm_multichannel_frontend #(
    parameter int CLK_FREQ          = 100_000_000,
    parameter int PDM_CLK_FREQ      = 1_800_000,
    parameter int NUM_CHANNELS      = 2,
    parameter int PDM_CHANNEL       = 1,
    parameter int CIC_STAGES        = 4,
    parameter int DECIMATION_FACTOR = 64,
    parameter int DATA_WIDTH        = 16,
    parameter int OUT_FIFO_DEPTH    = 4
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         enable,
    output logic                         M_CLK,
    output logic                         M_LRSEL,
    input  logic                         M_DATA,
    output logic signed [DATA_WIDTH-1:0] pcm_data,
    output logic                         pcm_channel,
    output logic                         pcm_valid,
    input  logic                         pcm_ready,
    output logic                         overflow,
    input  logic                         overflow_clr
);
    localparam int HP  = CLK_FREQ / (2 * PDM_CLK_FREQ);
    localparam int DVW = $clog2(HP);
    localparam int LR  = $clog2(DECIMATION_FACTOR);
    localparam int N   = CIC_STAGES;
    localparam int W   = N * LR + 2;
    localparam int DW  = DATA_WIDTH;
    localparam int SH  = W > DW ? W - DW : 0;
    localparam int AW  = $clog2(OUT_FIFO_DEPTH);
    localparam int WCW = $clog2(N + 1);
    localparam logic [DVW-1:0] DIV_MAX = DVW'(HP - 1);
    localparam logic [WCW-1:0] WARM    = WCW'(N);
    localparam logic [AW:0]    FULL    = (AW + 1)'(OUT_FIFO_DEPTH);
    localparam logic [1:0]     CH_EN   = NUM_CHANNELS == 2 ? 2'b11 : (PDM_CHANNEL == 1 ? 2'b10 : 2'b01);

    logic [DVW-1:0]      div;
    logic [1:0]          sync, cap, dec;
    logic                started, ch, push_raw, push, push_ch;
    logic [LR-1:0]       scnt [2];
    logic [WCW-1:0]      warm [2];
    logic signed [W-1:0] integ [2][N];
    logic signed [W-1:0] dly [2][N];
    logic signed [W-1:0] nd [N];
    logic signed [W-1:0] x, cmb_out;
    logic signed [DW-1:0] cic_out, push_data;

    assign M_LRSEL = NUM_CHANNELS == 2 ? 1'b0 : 1'(PDM_CHANNEL);
    // bit 1 -> +1, bit 0 -> -1 in W-bit two's complement
    assign x = {{(W - 1){~sync[1]}}, 1'b1};
    // ch0 samples on the cycle whose edge drops M_CLK, ch1 on the rising one;
    // ch1 waits for the first ch0 sample so every frame completes ch0 first
    assign cap[0] = enable && div == DIV_MAX && M_CLK && CH_EN[0];
    assign cap[1] = enable && div == DIV_MAX && !M_CLK && CH_EN[1] && (started || NUM_CHANNELS == 1);
    assign ch = dec[1];

    always_comb begin
        cmb_out = integ[ch][N-1];
        for (int k = 0; k < N; k++) begin
            nd[k] = cmb_out;
            cmb_out = cmb_out - dly[ch][k];
        end
    end

    assign cic_out = DW'(cmb_out >>> SH);
    assign push_raw = enable && |dec && warm[ch] == WARM;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync <= '0;
            div <= '0;
            M_CLK <= 1'b0;
            started <= 1'b0;
            dec <= '0;
            for (int c = 0; c < 2; c++) begin
                scnt[c] <= '0;
                warm[c] <= '0;
                for (int k = 0; k < N; k++) begin
                    integ[c][k] <= '0;
                    dly[c][k] <= '0;
                end
            end
        end else begin
            sync <= {sync[0], M_DATA};
            div <= (!enable || div == DIV_MAX) ? '0 : div + 1'b1;
            M_CLK <= enable && (M_CLK ^ (div == DIV_MAX));
            started <= enable && (started || cap[0]);
            dec <= {cap[1] && &scnt[1], cap[0] && &scnt[0]};
            for (int c = 0; c < 2; c++) begin
                if (!enable) begin
                    scnt[c] <= '0;
                    warm[c] <= '0;
                    for (int k = 0; k < N; k++) begin
                        integ[c][k] <= '0;
                        dly[c][k] <= '0;
                    end
                end else begin
                    if (cap[c]) begin
                        scnt[c] <= scnt[c] + 1'b1;
                        integ[c][0] <= integ[c][0] + x;
                        for (int k = 1; k < N; k++) integ[c][k] <= integ[c][k] + integ[c][k-1];
                    end
                    if (dec[c]) begin
                        warm[c] <= warm[c] == WARM ? WARM : warm[c] + 1'b1;
                        for (int k = 0; k < N; k++) dly[c][k] <= nd[k];
                    end
                end
            end
        end
    end

`ifdef PDM_DC_BLOCK_EN
    localparam int EW = DW + 4;
    localparam logic signed [DW-1:0] PMAX = {1'b0, {(DW - 1){1'b1}}};
    localparam logic signed [DW-1:0] NMIN = {1'b1, {(DW - 1){1'b0}}};
    logic                 s_vld, s_ch;
    logic signed [DW-1:0] s_x;
    logic signed [EW-1:0] xp [2];
    logic signed [EW-1:0] yp [2];
    logic signed [EW-1:0] y;

    assign y = EW'(s_x) - xp[s_ch] + yp[s_ch] - (yp[s_ch] >>> 8);
    assign push = enable && s_vld;
    assign push_ch = s_ch;
    assign push_data = y > EW'(PMAX) ? PMAX : y < EW'(NMIN) ? NMIN : y[DW-1:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s_vld <= 1'b0;
            s_ch <= 1'b0;
            s_x <= '0;
            for (int c = 0; c < 2; c++) begin
                xp[c] <= '0;
                yp[c] <= '0;
            end
        end else begin
            s_vld <= push_raw;
            s_ch <= ch;
            s_x <= cic_out;
            for (int c = 0; c < 2; c++) begin
                if (!enable) begin
                    xp[c] <= '0;
                    yp[c] <= '0;
                end else if (s_vld && s_ch == 1'(c)) begin
                    xp[c] <= EW'(s_x);
                    yp[c] <= y;
                end
            end
        end
    end
`else
    assign push = push_raw;
    assign push_ch = ch;
    assign push_data = cic_out;
`endif

    logic [DW:0]   mem [OUT_FIFO_DEPTH];
    logic [AW-1:0] wp, rp;
    logic [AW:0]   cnt;
    logic          pop, full, wr;

    assign pcm_valid = cnt != '0;
    assign {pcm_channel, pcm_data} = mem[rp];
    assign pop = pcm_valid && pcm_ready;
    assign full = cnt == FULL;
    // a simultaneous pop frees the slot, so a push into a full FIFO still lands
    assign wr = push && (!full || pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wp <= '0;
            rp <= '0;
            cnt <= '0;
            overflow <= 1'b0;
            for (int i = 0; i < OUT_FIFO_DEPTH; i++) mem[i] <= '0;
        end else begin
            if (wr) begin
                mem[wp] <= {push_ch, push_data};
                wp <= wp + 1'b1;
            end
            if (pop) rp <= rp + 1'b1;
            cnt <= cnt + (AW + 1)'(wr) - (AW + 1)'(pop);
            overflow <= (push && full && !pop) || (overflow && !overflow_clr);
        end
    end
endmodule
